// File: rtl/fifo_flags.sv
// fifo_flags: single-clock FIFO with registered show-ahead head, occupancy count,
// almost-full/almost-empty thresholds, sticky overflow/underflow and synchronous flush
module fifo_flags #(
    parameter int D_WIDTH = 6,
    parameter int DEPTH = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] up_data,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic               err_clr,
    output logic [D_WIDTH-1:0] down_data,
    output logic [CW-1:0]      count,
    output logic               empty,
    output logic               full,
    output logic               almost_full,
    output logic               almost_empty,
    output logic               overflow,
    output logic               underflow
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C = CW'(AE_LEVEL);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [D_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]      wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
    logic [CW-1:0]      count_next;
    logic [D_WIDTH-1:0] down_data_next;
    logic               pop_ok, push_ok;

    always_comb begin
        pop_ok = pop & (count != '0);
        push_ok = push & ((count != DEPTH_C) | pop_ok);
        wr_ptr_next = flush ? '0 : !push_ok ? wr_ptr : (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
        rd_ptr_next = flush ? '0 : !pop_ok ? rd_ptr : (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
        count_next = flush ? '0 : count + CW'(push_ok) - CW'(pop_ok);
        // the new head is the incoming word when it lands in an otherwise empty FIFO
        down_data_next = (count_next == '0) ? '0 :
                         ((count == '0) || (pop_ok && count == CW'(1))) ? up_data : mem[rd_ptr_next];
    end

    always_ff @(posedge clk)
        if (push_ok && !flush) mem[wr_ptr] <= up_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            down_data    <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_full  <= (AF_LEVEL == 0);
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_next;
            rd_ptr       <= rd_ptr_next;
            count        <= count_next;
            down_data    <= down_data_next;
            empty        <= count_next == '0;
            full         <= count_next == DEPTH_C;
            almost_full  <= count_next >= AF_C;
            almost_empty <= count_next <= AE_C;
            overflow     <= (!flush && push && !push_ok) || (overflow && !err_clr);
            underflow    <= (!flush && pop && count == '0) || (underflow && !err_clr);
        end
    end
endmodule
